// File: rtl/sdf_bitrev_reorder.sv
// Output reorder buffer for the R2SDF FFT pipeline.
// Frames arrive in bit-reversed bin order. Each one is written into one bank
// of a ping-pong pair and then read back in natural bin order, with
// start-of-frame and end-of-frame markers added on the way out.
//
// Handshake: di_en is a pure valid with no ready. A frame is N consecutive
// di_en cycles, and any di_en=0 cycle abandons a partial frame. do_en is a
// pure valid with no backpressure, and there is exactly one output word per
// do_en cycle. do_re/do_im/do_idx/do_sop/do_eop are 0 whenever do_en is 0.
`timescale 1ns/1ps

`ifndef DATA_IN_WIDTH
`define DATA_IN_WIDTH 16
`endif
`ifndef C2LOG_FFT_POINTS
`define C2LOG_FFT_POINTS 3
`endif

module sdf_bitrev_reorder #(
    parameter int DATA_WIDTH = `DATA_IN_WIDTH,
    parameter int LOG2_N     = `C2LOG_FFT_POINTS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  di_en,
    input  logic [DATA_WIDTH-1:0] di_re,
    input  logic [DATA_WIDTH-1:0] di_im,
    output logic                  do_en,
    output logic [DATA_WIDTH-1:0] do_re,
    output logic [DATA_WIDTH-1:0] do_im,
    output logic                  do_sop,
    output logic                  do_eop,
    output logic [LOG2_N-1:0]     do_idx
);

    localparam int N = 1 << LOG2_N;
    localparam int WORD_W = 2 * DATA_WIDTH;
    localparam logic [LOG2_N-1:0] LAST = {LOG2_N{1'b1}};

    typedef enum logic {
        S_IDLE = 1'b0,
        S_READ = 1'b1
    } rd_state_t;

    // Storage banks. These are deliberately not reset.
    logic [WORD_W-1:0] mem0 [0:N-1];
    logic [WORD_W-1:0] mem1 [0:N-1];

    // Write side
    logic [LOG2_N-1:0] wr_cnt;
    logic              wr_bank;
    logic [1:0]        wr_set;

    // Read side
    rd_state_t         state;
    logic [LOG2_N-1:0] rd_cnt;
    logic              rd_bank;
    logic [1:0]        rd_clr;
    logic              rd_fire;
    logic              other_full;

    // full[b] means bank b holds a complete frame that has not yet been read out
    logic [1:0]        full;

    // Read pipeline stage, aligned with the RAM read data
    logic [WORD_W-1:0] rd_data;
    logic              rd_valid;
    logic [LOG2_N-1:0] rd_idx;

    // A sample arriving at count c belongs to bin bitrev(c)
    function automatic logic [LOG2_N-1:0] bitrev(input logic [LOG2_N-1:0] a);
        logic [LOG2_N-1:0] r;
        r = '0;
        for (int i = 0; i < LOG2_N; i++) begin
            r[i] = a[LOG2_N-1-i];
        end
        return r;
    endfunction

    // A read is issued whenever the current read bank holds a frame. In READ
    // the bank stays full until its last read, so this also covers READ.
    assign rd_fire    = (state == S_READ) || full[rd_bank];
    // The other bank counts as full when it completes on this same edge
    assign other_full = full[~rd_bank] | wr_set[~rd_bank];

    // Full-flag set/clear requests for the current edge
    always_comb begin
        wr_set = 2'b00;
        rd_clr = 2'b00;
        if (di_en && (wr_cnt == LAST)) begin
            wr_set[wr_bank] = 1'b1;
        end
        if ((state == S_READ) && (rd_cnt == LAST)) begin
            rd_clr[rd_bank] = 1'b1;
        end
    end

    // Write counter and bank select. A di_en gap discards the partial frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt  <= '0;
            wr_bank <= 1'b0;
        end else if (di_en) begin
            if (wr_cnt == LAST) begin
                wr_cnt  <= '0;
                wr_bank <= ~wr_bank;
            end else begin
                wr_cnt <= wr_cnt + 1'b1;
            end
        end else begin
            wr_cnt <= '0;
        end
    end

    // Frame-complete flags. Setting one bank and clearing the other on the
    // same edge are independent operations.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 2'b00;
        end else begin
            full <= (full & ~rd_clr) | wr_set;
        end
    end

    // Bank writes at the bit-reversed address, plus the registered read port
    always_ff @(posedge clk) begin
        if (di_en) begin
            if (wr_bank) begin
                mem1[bitrev(wr_cnt)] <= {di_re, di_im};
            end else begin
                mem0[bitrev(wr_cnt)] <= {di_re, di_im};
            end
        end
        if (rd_fire) begin
            rd_data <= rd_bank ? mem1[rd_cnt] : mem0[rd_cnt];
        end
    end

    // Read FSM. IDLE issues index 0 as soon as a bank is full. READ walks the
    // bank and chains straight into the other bank when it is already full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            rd_cnt  <= '0;
            rd_bank <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (full[rd_bank]) begin
                        state  <= S_READ;
                        rd_cnt <= rd_cnt + 1'b1;
                    end
                end
                S_READ: begin
                    if (rd_cnt == LAST) begin
                        rd_cnt  <= '0;
                        rd_bank <= ~rd_bank;
                        state   <= other_full ? S_READ : S_IDLE;
                    end else begin
                        rd_cnt <= rd_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Valid and index travel alongside the RAM read latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_idx   <= '0;
        end else begin
            rd_valid <= rd_fire;
            rd_idx   <= rd_cnt;
        end
    end

    // Registered output stage. Everything is forced to zero when not valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            do_en  <= 1'b0;
            do_re  <= '0;
            do_im  <= '0;
            do_idx <= '0;
            do_sop <= 1'b0;
            do_eop <= 1'b0;
        end else begin
            do_en  <= rd_valid;
            do_re  <= rd_valid ? rd_data[WORD_W-1:DATA_WIDTH] : '0;
            do_im  <= rd_valid ? rd_data[DATA_WIDTH-1:0] : '0;
            do_idx <= rd_valid ? rd_idx : '0;
            do_sop <= rd_valid && (rd_idx == '0);
            do_eop <= rd_valid && (rd_idx == LAST);
        end
    end

endmodule

// File: tb/tb_sdf_bitrev_reorder.sv
// Bench for sdf_bitrev_reorder. It uses one N=8 instance and one N=16
// instance, which are exercised one at a time through a shared driver. A
// frame-level model predicts every output word and the exact cycle on which
// it appears.
`timescale 1ns/1ps

module tb_sdf_bitrev_reorder;

    localparam int W = 16;
    localparam int EXP_W = 4 + 2 * W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Shared driver signals; sel picks the active instance (0: N=8, 1: N=16)
    logic         sel;
    logic         di_en;
    logic [W-1:0] di_re, di_im;

    logic         en8, sop8, eop8, en16, sop16, eop16;
    logic [W-1:0] re8, im8, re16, im16;
    logic [2:0]   idx8;
    logic [3:0]   idx16;

    sdf_bitrev_reorder #(.DATA_WIDTH(W), .LOG2_N(3)) u8 (
        .clk(clk), .rst(rst), .di_en(di_en & ~sel), .di_re(di_re), .di_im(di_im),
        .do_en(en8), .do_re(re8), .do_im(im8), .do_sop(sop8), .do_eop(eop8), .do_idx(idx8)
    );

    sdf_bitrev_reorder #(.DATA_WIDTH(W), .LOG2_N(4)) u16 (
        .clk(clk), .rst(rst), .di_en(di_en & sel), .di_re(di_re), .di_im(di_im),
        .do_en(en16), .do_re(re16), .do_im(im16), .do_sop(sop16), .do_eop(eop16), .do_idx(idx16)
    );

    logic         o_en, o_sop, o_eop;
    logic [W-1:0] o_re, o_im;
    logic [3:0]   o_idx;
    assign o_en  = sel ? en16 : en8;
    assign o_sop = sel ? sop16 : sop8;
    assign o_eop = sel ? eop16 : eop8;
    assign o_re  = sel ? re16 : re8;
    assign o_im  = sel ? im16 : im8;
    assign o_idx = sel ? idx16 : {1'b0, idx8};

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [EXP_W-1:0] exp_q[$];
    int               exp_cyc_q[$];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int rev(input int v, input int bits);
        int r;
        r = 0;
        for (int i = 0; i < bits; i++) begin
            if (((v >> i) & 1) != 0) r |= 1 << (bits - 1 - i);
        end
        return rev_ret(r);
    endfunction

    function automatic int rev_ret(input int r);
        return r;
    endfunction

    // ---------------- reference model ----------------
    // Arrival j of a frame carries bin rev(j). A complete frame captured on
    // edge E presents bin k at edge E+2+k, unless the previous frame is still
    // draining, in which case it follows that frame directly.
    int           edge_n = 0;
    int           cur_n;
    int           cur_lg;
    int           fcnt = 0;
    int           last_start = -1000;
    logic [W-1:0] f_re[16];
    logic [W-1:0] f_im[16];

    assign cur_n  = sel ? 16 : 8;
    assign cur_lg = sel ? 4 : 3;

    always @(posedge clk) begin
        int s;
        int j;
        edge_n++;
        if (rst) begin
            fcnt = 0;
            last_start = -1000;
        end else if (di_en) begin
            f_re[fcnt] = di_re;
            f_im[fcnt] = di_im;
            fcnt++;
            if (fcnt == cur_n) begin
                s = edge_n + 2;
                if (last_start + cur_n > s) s = last_start + cur_n;
                last_start = s;
                for (int k = 0; k < cur_n; k++) begin
                    j = rev(k, cur_lg);
                    exp_q.push_back({4'(k), f_re[j], f_im[j]});
                    exp_cyc_q.push_back(s + k);
                end
                fcnt = 0;
            end
        end else begin
            fcnt = 0;
        end
    end

    // Output monitor, sampling on the falling edge
    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        if (!rst) begin
            if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == edge_n) begin
                e = exp_q.pop_front();
                void'(exp_cyc_q.pop_front());
                check("en", 64'(o_en), 64'd1);
                check("idx", 64'(o_idx), 64'(e[EXP_W-1:2*W]));
                check("re", 64'(o_re), 64'(e[2*W-1:W]));
                check("im", 64'(o_im), 64'(e[W-1:0]));
                check("sop", 64'(o_sop), 64'(e[EXP_W-1:2*W] == 4'd0));
                check("eop", 64'(o_eop), 64'(int'(e[EXP_W-1:2*W]) == cur_n - 1));
            end else begin
                check("idle_en", 64'(o_en), 64'd0);
                check("idle_data", 64'({o_re, o_im}), 64'd0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // mode 0: random, 1: ramp base+k / -(base+k), 2: extremes
    task automatic send(input int n, input int mode, input int base);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            di_en = 1'b1;
            case (mode)
                1: begin
                    di_re = W'(base + k);
                    di_im = W'(0 - (base + k));
                end
                2: begin
                    di_re = (k % 2 == 0) ? 16'h7fff : 16'h8000;
                    di_im = (k % 3 == 0) ? 16'h8000 : 16'h7fff;
                end
                default: begin
                    di_re = W'($urandom);
                    di_im = W'($urandom);
                end
            endcase
        end
    endtask

    task automatic idle(input int c);
        for (int k = 0; k < c; k++) begin
            @(negedge clk);
            di_en = 1'b0;
            di_re = W'($urandom);
            di_im = W'($urandom);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t;
        rst   = 1'b1;
        sel   = 1'b0;
        di_en = 1'b0;
        di_re = '0;
        di_im = '0;
        repeat (2) @(negedge clk);
        check("rst_en", 64'(o_en), 64'd0);
        check("rst_sop_eop", 64'({o_sop, o_eop}), 64'd0);
        check("rst_data", 64'({o_re, o_im, o_idx}), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic reorder
        send(8, 1, 0);
        idle(12);

        // Back-to-back: three frames, values 16f+k
        send(8, 1, 0);
        send(8, 1, 16);
        send(8, 1, 32);
        idle(14);

        // Frame drop: partial of 5, one idle cycle, then a full frame
        send(5, 1, 100);
        idle(1);
        send(8, 1, 200);
        idle(12);

        // Random frames with random gaps and occasional partial frames
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                send($urandom_range(1, 7), 0, 0);
                idle($urandom_range(1, 2));
            end
            send(8, 0, 0);
            idle($urandom_range(0, 3));
        end
        idle(14);

        // Reset during READ at output index 3
        send(8, 1, 50);
        idle(1);
        t = 0;
        while (!(o_en && o_idx == 4'd3) && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("rst_wait_timeout", 64'(t < 40), 64'd1);
        #1;
        rst = 1'b1;
        exp_q.delete();
        exp_cyc_q.delete();
        #1;
        check("midrst_en", 64'(o_en), 64'd0);
        check("midrst_data", 64'({o_re, o_im, o_idx, o_sop, o_eop}), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send(8, 1, 60);
        idle(12);

        // Extremes
        send(8, 2, 0);
        send(8, 2, 0);
        idle(14);

        // Gapped frames on the N=16 instance
        sel = 1'b1;
        idle(2);
        for (int i = 0; i < 3; i++) begin
            send(16, 0, 0);
            idle(5);
        end
        idle(24);

        check("drain", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Safety net in case the stimulus ever stalls
    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
